// File: rtl/mono_timestamp_fifo.sv
// mono_timestamp_fifo: timestamps TS_IN rising edges on a 48-bit counter into a FWFT FIFO of tagged 32-bit words
// Ports: BUS_CLK clock, BUS_RST async active-high reset, EN capture enable, RST_TS timestamp clear,
//   TS_IN async pulse input, FIFO_READ/FIFO_EMPTY/FIFO_DATA FWFT read side, LOST_CNT saturating drop count.
// Build option: define MONO_TS_TOT_EN to also measure pulse width and emit a third word per event.
module mono_timestamp_fifo #(
  parameter logic [3:0] IDENTIFIER = 4'b0110,
  parameter int DEPTH = 16
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST,
  input  logic        EN,
  input  logic        RST_TS,
  input  logic        TS_IN,
  input  logic        FIFO_READ,
  output logic        FIFO_EMPTY,
  output logic [31:0] FIFO_DATA,
  output logic [7:0]  LOST_CNT
);
  localparam int AW = $clog2(DEPTH);
`ifdef MONO_TS_TOT_EN
  localparam int NW = 3;
  typedef enum logic [2:0] {IDLE, HIGH, WR0, WR1, WR2} state_t;
  logic [15:0] tot;
`else
  localparam int NW = 2;
  typedef enum logic [1:0] {IDLE, WR0, WR1} state_t;
`endif
  state_t state, state_nx;
  logic [2:0] sync;
  logic rise, fall, room, wr, rd, take, drop;
  logic [47:0] ts, ts_lat;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] occ;
  logic [31:0] wdata;
  logic [31:0] mem [DEPTH];
  assign rise = sync[1] & ~sync[2];
  assign fall = ~sync[1] & sync[2];
  // room for every word of one event, so an accepted event is never split
  assign room = ((AW+1)'(DEPTH) - occ) >= (AW+1)'(NW);
  assign FIFO_EMPTY = occ == '0;
  assign FIFO_DATA = FIFO_EMPTY ? '0 : mem[rptr];
  assign rd = FIFO_READ & ~FIFO_EMPTY;
  always_comb begin
    state_nx = state;
    wr = 1'b0;
    wdata = '0;
    take = 1'b0;
    drop = rise & (state != IDLE);
    case (state)
`ifdef MONO_TS_TOT_EN
      IDLE: begin
        take = rise & EN;
        state_nx = take ? HIGH : IDLE;
      end
      // EN is not consulted here: a started pulse always completes
      HIGH: begin
        drop = fall & ~room;
        state_nx = fall ? (room ? WR0 : IDLE) : HIGH;
      end
`else
      IDLE: begin
        take = rise & EN & room;
        drop = rise & EN & ~room;
        state_nx = take ? WR0 : IDLE;
      end
`endif
      WR0: begin
        wr = 1'b1;
        wdata = {IDENTIFIER, 4'h1, ts_lat[47:24]};
        state_nx = WR1;
      end
      WR1: begin
        wr = 1'b1;
        wdata = {IDENTIFIER, 4'h2, ts_lat[23:0]};
`ifdef MONO_TS_TOT_EN
        state_nx = WR2;
      end
      WR2: begin
        wr = 1'b1;
        wdata = {IDENTIFIER, 4'h3, 8'h00, tot};
        state_nx = IDLE;
`else
        state_nx = IDLE;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      state <= IDLE;
      sync <= '0;
      ts <= '0;
      ts_lat <= '0;
      wptr <= '0;
      rptr <= '0;
      occ <= '0;
      LOST_CNT <= '0;
    end else begin
      state <= state_nx;
      sync <= {sync[1:0], TS_IN};
      ts <= RST_TS ? '0 : ts + 48'd1;
      if (take) ts_lat <= ts;
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      occ <= occ + (AW+1)'(wr) - (AW+1)'(rd);
      if (drop && LOST_CNT != 8'hFF) LOST_CNT <= LOST_CNT + 8'd1;
    end
  end
`ifdef MONO_TS_TOT_EN
  // the detection cycle already counts as one high cycle
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) tot <= '0;
    else if (take) tot <= 16'd1;
    else if (state == HIGH && sync[1] && tot != 16'hFFFF) tot <= tot + 16'd1;
  end
`endif
  always_ff @(posedge BUS_CLK) begin
    if (wr) mem[wptr] <= wdata;
  end
endmodule
